// File: rtl/basic_handshake_arbiter.sv
// rtl/basic_handshake_arbiter.sv - round-robin requester arbiter driving a valid/busy completer handshake
// Optional SEND watchdog is compiled in when BASIC_HS_ARB_TIMEOUT_EN is defined.
module basic_handshake_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DW          = 4,
    parameter int TIMEOUT_CYC = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*DW-1:0] req_data,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    done,
    output logic                  valid,
    output logic [DW-1:0]         data_out,
    input  logic                  busy,
    output logic                  err
);
    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, SEND, DRAIN, DONE} state_t;

    state_t             state, state_nxt;
    logic [PW-1:0]      ptr, ptr_nxt, winner, winner_nxt, pick;
    logic               found;
    logic [NUM_REQ-1:0] gnt_nxt, done_nxt, pick_oh;
    logic               valid_nxt;
    logic [DW-1:0]      data_nxt, pick_data;

`ifdef BASIC_HS_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt, cnt_nxt;
    logic          err_nxt;
`endif

    // First asserted request at or after ptr, wrapping NUM_REQ-1 -> 0.
    always_comb begin
        logic [PW:0] idx;
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr} + (PW+1)'(k);
            if (idx >= (PW+1)'(NUM_REQ)) begin
                idx = idx - (PW+1)'(NUM_REQ);
            end
            if (!found && req[idx[PW-1:0]]) begin
                found = 1'b1;
                pick  = idx[PW-1:0];
            end
        end
    end

    always_comb begin
        pick_oh   = '0;
        pick_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == PW'(i)) begin
                pick_oh[i] = 1'b1;
                pick_data  = req_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        winner_nxt = winner;
        gnt_nxt    = gnt;
        done_nxt   = '0;
        valid_nxt  = valid;
        data_nxt   = data_out;
`ifdef BASIC_HS_ARB_TIMEOUT_EN
        cnt_nxt    = cnt;
        err_nxt    = 1'b0;
`endif
        case (state)
            IDLE: begin
                gnt_nxt   = '0;
                valid_nxt = 1'b0;
                data_nxt  = '0;
`ifdef BASIC_HS_ARB_TIMEOUT_EN
                cnt_nxt   = '0;
`endif
                if (found) begin
                    winner_nxt = pick;
                    gnt_nxt    = pick_oh;
                    valid_nxt  = 1'b1;
                    data_nxt   = pick_data;
                    state_nxt  = SEND;
                end
            end
            SEND: begin
                if (busy) begin
                    valid_nxt = 1'b0;
                    data_nxt  = '0;
                    state_nxt = DRAIN;
                end
`ifdef BASIC_HS_ARB_TIMEOUT_EN
                else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
                    // Abort is reported as err plus a done pulse so the requester still releases.
                    valid_nxt = 1'b0;
                    data_nxt  = '0;
                    err_nxt   = 1'b1;
                    done_nxt  = gnt;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
`endif
            end
            DRAIN: begin
                if (!busy) begin
                    done_nxt  = gnt;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                gnt_nxt   = '0;
                ptr_nxt   = (winner == PW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            ptr      <= '0;
            winner   <= '0;
            gnt      <= '0;
            done     <= '0;
            valid    <= 1'b0;
            data_out <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            winner   <= winner_nxt;
            gnt      <= gnt_nxt;
            done     <= done_nxt;
            valid    <= valid_nxt;
            data_out <= data_nxt;
        end
    end

`ifdef BASIC_HS_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            err <= err_nxt;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
    assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_basic_handshake_arbiter.sv
// tb/tb_basic_handshake_arbiter.sv - randomized self-checking bench for basic_handshake_arbiter
// Watchdog scenario follows BASIC_HS_ARB_TIMEOUT_EN the same way the design does.
module tb_basic_handshake_arbiter;
    localparam int N  = 4;
    localparam int DW = 4;
    localparam int TO = 8;
    localparam int PW = $clog2(N);

    logic            clk = 1'b0;
    logic            rstn;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    gnt, done;
    logic            valid, busy, err;
    logic [DW-1:0]   data_out;

    int checks = 0;
    int errors = 0;
    int m_ptr  = 0;

    basic_handshake_arbiter #(.NUM_REQ(N), .DW(DW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rstn(rstn), .req(req), .req_data(req_data), .gnt(gnt), .done(done),
        .valid(valid), .data_out(data_out), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded 100000 time units, expected completion");
        $fatal(1);
    end

    // Round-robin reference: first set bit at or after p, ascending with wrap.
    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        int idx;
        rr_pick = -1;
        for (int k = 0; k < N; k++) begin
            idx = (p + k) % N;
            if (rr_pick < 0 && r[idx[PW-1:0]]) rr_pick = idx;
        end
    endfunction

    task automatic rand_data();
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'($urandom);
    endtask

    // Acts as completer for one transfer and reports what it observed.
    task automatic serve(input int d1, input int h, input logic [N-1:0] late, input bit drop,
                         output logic [N-1:0] g, output logic [DW-1:0] d, output int wcyc,
                         output int vcyc, output logic [N-1:0] dn, output int viol);
        logic [N*DW-1:0] saved;
        int n;
        g = '0; d = '0; wcyc = 0; vcyc = 0; dn = '0; viol = 0; saved = req_data;
        while (gnt == '0 && wcyc < 40) begin
            @(posedge clk); #1; wcyc++;
            if (done !== '0 || err !== 1'b0) viol++;
            if (gnt == '0 && valid !== 1'b0) viol++;
        end
        if (gnt == '0) begin
            viol += 100;
            return;
        end
        g = gnt; d = data_out; busy = 1'b0; n = 0;
        while (valid === 1'b1 && n < d1 + 40) begin
            vcyc++;
            if (gnt !== g || data_out !== d || done !== '0 || err !== 1'b0) viol++;
            rand_data();
            if (n == d1) busy = 1'b1;
            @(posedge clk); #1; n++;
        end
        if (valid !== 1'b0 || data_out !== '0 || gnt !== g || done !== '0) viol++;
        req = req | late;
        for (int k = 1; k < h; k++) begin
            @(posedge clk); #1;
            if (valid !== 1'b0 || gnt !== g || done !== '0) viol++;
        end
        busy = 1'b0; n = 0;
        do begin @(posedge clk); #1; n++; end while (done == '0 && n < 40);
        if (n != 1) viol++;
        dn = done;
        if (gnt !== g || err !== 1'b0 || valid !== 1'b0) viol++;
        req_data = saved;
        @(posedge clk); #1;
        if (gnt !== '0 || done !== '0) viol++;
        if (drop) req = req & ~g;
    endtask

    task automatic test_reset();
        int bad;
        bad = 0; rstn = 1'b0; req = '1; busy = 1'b1; req_data = '1;
        repeat (3) begin
            @(posedge clk); #1;
            if (gnt !== '0 || done !== '0 || valid !== 1'b0 || data_out !== '0 || err !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL reset_outputs: %0d bad cycles, expected 0", bad); end
        req = '0;
        @(negedge clk); rstn = 1'b1;
        bad = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (gnt !== '0 || valid !== 1'b0 || done !== '0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL stale_busy: %0d cycles with grant, expected 0", bad); end
        busy = 1'b0; m_ptr = 0;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] g, dn, eg;
        logic [DW-1:0] d;
        int wcyc, vcyc, viol, ew, d1;
        req = '1;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'(i + 1);
        for (int t = 0; t < 5; t++) begin
            d1 = t % 2;
            serve(d1, 1 + t % 3, '0, 1'b0, g, d, wcyc, vcyc, dn, viol);
            ew = t % N; eg = N'(1) << ew;
            checks++; if (g !== eg) begin errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", t, g, eg); end
            checks++; if (d !== DW'(ew + 1)) begin errors++; $display("FAIL rr_data[%0d]: got %h expected %h", t, d, ew + 1); end
            checks++; if (dn !== eg) begin errors++; $display("FAIL rr_done[%0d]: got %b expected %b", t, dn, eg); end
            checks++; if (wcyc != 1 || vcyc != d1 + 1 || viol != 0) begin
                errors++; $display("FAIL rr_timing[%0d]: wait %0d valid %0d viol %0d expected 1 %0d 0", t, wcyc, vcyc, viol, d1 + 1);
            end
            m_ptr = (ew + 1) % N;
        end
        req = '0;
    endtask

    task automatic test_single();
        logic [N-1:0] g, dn;
        logic [DW-1:0] d;
        int wcyc, vcyc, viol;
        rand_data(); req_data[DW-1:0] = 4'hA; req = 4'b0001;
        serve(1, 2, '0, 1'b1, g, d, wcyc, vcyc, dn, viol);
        checks++; if (g !== 4'b0001 || dn !== 4'b0001) begin errors++; $display("FAIL single_gnt_done: got %b %b expected 0001 0001", g, dn); end
        checks++; if (d !== 4'hA) begin errors++; $display("FAIL single_data: got %h expected a", d); end
        checks++; if (vcyc != 2 || wcyc != 1 || viol != 0) begin
            errors++; $display("FAIL single_timing: valid %0d wait %0d viol %0d expected 2 1 0", vcyc, wcyc, viol);
        end
        m_ptr = 1;
    endtask

    task automatic test_late_arrival();
        logic [N-1:0] g, dn;
        logic [DW-1:0] d, ed;
        int wcyc, vcyc, viol, ew;
        rand_data(); req = 4'b0001;
        serve(int'($urandom_range(0, 3)), 2, 4'b0100, 1'b1, g, d, wcyc, vcyc, dn, viol);
        checks++; if (g !== 4'b0001 || viol != 0) begin errors++; $display("FAIL late_first: got %b viol %0d expected 0001 0", g, viol); end
        m_ptr = 1;
        ew = rr_pick(req, m_ptr); ed = req_data[ew*DW +: DW];
        serve(1, 1, '0, 1'b1, g, d, wcyc, vcyc, dn, viol);
        checks++; if (g !== N'(1) << ew || d !== ed) begin errors++; $display("FAIL late_second: got %b %h expected %0d %h", g, d, ew, ed); end
        checks++; if (wcyc != 1 || dn !== g || viol != 0) begin errors++; $display("FAIL late_timing: wait %0d done %b viol %0d expected 1 gnt 0", wcyc, dn, viol); end
        m_ptr = (ew + 1) % N;
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] g, dn;
        logic [DW-1:0] d;
        int wcyc, vcyc, viol, n, bad;
        req = 4'b0010; busy = 1'b0; n = 0;
        do begin @(posedge clk); #1; n++; end while (gnt == '0 && n < 10);
        busy = 1'b1;
        @(posedge clk); #1;
        checks++; if (gnt !== 4'b0010 || valid !== 1'b0) begin errors++; $display("FAIL rm_drain: gnt %b valid %b expected 0010 0", gnt, valid); end
        #3 rstn = 1'b0;
        #1;
        checks++; if ({gnt, done, valid, data_out, err} !== '0) begin
            errors++; $display("FAIL rm_async: gnt %b done %b valid %b data %h err %b expected all 0", gnt, done, valid, data_out, err);
        end
        busy = 1'b0; bad = 0;
        repeat (2) begin @(posedge clk); #1; if (done !== '0 || gnt !== '0) bad++; end
        checks++; if (bad != 0) begin errors++; $display("FAIL rm_no_done: %0d bad cycles expected 0", bad); end
        @(negedge clk); rstn = 1'b1; m_ptr = 0;
        serve(1, 1, '0, 1'b1, g, d, wcyc, vcyc, dn, viol);
        checks++; if (g !== 4'b0010 || wcyc != 1 || viol != 0) begin
            errors++; $display("FAIL rm_regrant: got %b wait %0d viol %0d expected 0010 1 0", g, wcyc, viol);
        end
        m_ptr = 2;
    endtask

`ifdef BASIC_HS_ARB_TIMEOUT_EN
    task automatic test_watchdog();
        logic [N-1:0] g;
        int n, vcyc;
        req = 4'b1000; busy = 1'b0; n = 0;
        do begin @(posedge clk); #1; n++; end while (gnt == '0 && n < 10);
        g = gnt; vcyc = 0;
        while (valid === 1'b1 && vcyc < 40) begin
            vcyc++;
            if (err !== 1'b0) vcyc += 100;
            @(posedge clk); #1;
        end
        checks++; if (g !== 4'b1000 || vcyc != TO) begin errors++; $display("FAIL wd_valid: gnt %b valid cycles %0d expected 1000 %0d", g, vcyc, TO); end
        checks++; if (err !== 1'b1 || done !== g) begin errors++; $display("FAIL wd_pulse: err %b done %b expected 1 %b", err, done, g); end
        req = '0;
        @(posedge clk); #1;
        checks++; if (err !== 1'b0 || done !== '0 || gnt !== '0) begin errors++; $display("FAIL wd_clear: err %b done %b gnt %b expected 0", err, done, gnt); end
        m_ptr = 0;
    endtask
`else
    task automatic test_no_watchdog();
        int n, bad;
        req = 4'b1000; busy = 1'b0; n = 0;
        do begin @(posedge clk); #1; n++; end while (gnt == '0 && n < 10);
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL nw_grant: got %b expected 1000", gnt); end
        bad = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (valid !== 1'b1 || err !== 1'b0 || done !== '0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL nw_hold: %0d bad cycles expected 0", bad); end
        busy = 1'b1;
        @(posedge clk); #1;
        busy = 1'b0;
        @(posedge clk); #1;
        checks++; if (done !== 4'b1000 || err !== 1'b0) begin errors++; $display("FAIL nw_done: done %b err %b expected 1000 0", done, err); end
        req = '0;
        @(posedge clk); #1;
        checks++; if (gnt !== '0 || done !== '0) begin errors++; $display("FAIL nw_clear: gnt %b done %b expected 0", gnt, done); end
        m_ptr = 0;
    endtask
`endif

    task automatic test_random();
        logic [N-1:0] g, dn, eg, late;
        logic [DW-1:0] d, ed;
        int wcyc, vcyc, viol, ew, d1, h;
        for (int t = 0; t < 30; t++) begin
            rand_data();
            req = req | N'($urandom_range(0, (1 << N) - 1));
            if (req == '0) req = N'($urandom_range(1, (1 << N) - 1));
            ew = rr_pick(req, m_ptr); eg = N'(1) << ew; ed = req_data[ew*DW +: DW];
            d1 = int'($urandom_range(0, 3)); h = int'($urandom_range(1, 3));
            late = N'($urandom_range(0, (1 << N) - 1));
            serve(d1, h, late, 1'b1, g, d, wcyc, vcyc, dn, viol);
            checks++; if (g !== eg || d !== ed) begin errors++; $display("FAIL rnd_grant[%0d]: got %b %h expected %b %h", t, g, d, eg, ed); end
            checks++; if (dn !== eg) begin errors++; $display("FAIL rnd_done[%0d]: got %b expected %b", t, dn, eg); end
            checks++; if (wcyc != 1 || vcyc != d1 + 1 || viol != 0) begin
                errors++; $display("FAIL rnd_timing[%0d]: wait %0d valid %0d viol %0d expected 1 %0d 0", t, wcyc, vcyc, viol, d1 + 1);
            end
            m_ptr = (ew + 1) % N;
        end
        req = '0;
    endtask

    initial begin
        rstn = 1'b0; req = '0; busy = 1'b0; req_data = '0;
        test_reset();
        test_round_robin();
        test_single();
        test_late_arrival();
        test_reset_mid();
`ifdef BASIC_HS_ARB_TIMEOUT_EN
        test_watchdog();
`else
        test_no_watchdog();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/basic_handshake_arbiter.md
BASIC_HANDSHAKE_ARBITER -- requirements
Module: basic_handshake_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters, range 2..8.
REQ-002 Parameter DW, default 4: data width, matches completer data port.
REQ-003 Parameter TIMEOUT_CYC, default 8: SEND-state cycles without busy before abort (used only with REQ-030).
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 req  input  NUM_REQ  per-requester request level, held until matching done.
REQ-007 req_data  input  NUM_REQ*DW  requester i data in bits [i*DW +: DW].
REQ-008 gnt  output  NUM_REQ  one-hot grant, high from grant edge until DONE exit.
REQ-009 done  output  NUM_REQ  one-cycle completion pulse to granted requester.
REQ-010 valid  output  1  to completer valid.
REQ-011 data_out  output  DW  to completer data_in.
REQ-012 busy  input  1  from completer busy.
REQ-013 err  output  1  one-cycle timeout pulse; constant 0 without REQ-030.

Function
REQ-014 FSM states IDLE, SEND, DRAIN, DONE; all outputs registered.
REQ-015 IDLE: at an edge with req != 0, select winner round-robin, starting search at ptr, ascending index with wrap NUM_REQ-1 -> 0; same edge: gnt[winner]=1, valid=1, data_out=req_data of winner, state SEND.
REQ-016 IDLE with req == 0: stay IDLE, valid=0, data_out=0, gnt=0.
REQ-017 data_out latched at grant; req_data changes after grant do not affect data_out.
REQ-018 SEND: hold valid=1, data_out stable; at edge sampling busy=1: valid=0, data_out=0, state DRAIN.
REQ-019 DRAIN: at edge sampling busy=0: done[winner]=1 for one cycle, state DONE; busy=1 keeps DRAIN.
REQ-020 DONE: one cycle; at next edge gnt=0, done=0, ptr=(winner+1) mod NUM_REQ, state IDLE.
REQ-021 Requester deasserts req on the edge after done; a req still high when IDLE samples it is a new request.
REQ-022 Nominal transfer: grant edge E0, completer sets busy E1, DRAIN E2, done E4, IDLE E5; next grant no earlier than E5.
REQ-023 Requests arriving during SEND/DRAIN/DONE are not lost; they are arbitrated in next IDLE.
REQ-024 gnt and done never have more than one bit set; done bit always equals current gnt bit.
REQ-025 busy high while in IDLE (stale) is ignored; no grant issued on busy alone.

Reset
REQ-026 rstn low forces immediately: state IDLE, ptr=0, gnt=0, done=0, valid=0, data_out=0, err=0, timeout counter 0.
REQ-027 Reset mid-transfer abandons the transfer with no done pulse; requester retries by holding req.
REQ-028 First IDLE edge after rstn rises arbitrates normally.

Configuration
REQ-029 Macro BASIC_HS_ARB_TIMEOUT_EN selects the SEND watchdog.
REQ-030 Defined: counter clears on entering SEND, increments each SEND cycle with busy=0; at count TIMEOUT_CYC: valid=0, data_out=0, err=1 and done[winner]=1 for one cycle, state DONE.
REQ-031 Not defined: no counter logic; SEND waits indefinitely for busy; err tied 0.

Verification
REQ-032 req=0001, req_data[3:0]=0xA, completer attached -> valid high E0..E2, data_out=0xA, completer data_rcvd=0xA at E2, done[0] at E4, gnt[0] low at E5.
REQ-033 req=1111 held continuously, data 0x1/0x2/0x3/0x4 -> grants in order 0,1,2,3,0, each done once per grant, completer receives 0x1,0x2,0x3,0x4.
REQ-034 req=0100 arriving during requester 0 DRAIN -> served in next IDLE, ptr=1 skips to 2, no loss.
REQ-035 rstn low during DRAIN of requester 1 -> all outputs 0 same time, no done; after release with req=0010 held -> regranted requester 1.
REQ-036 Macro defined, busy forced 0, TIMEOUT_CYC=8 -> valid drops after 8 SEND cycles, err and done[winner] pulse together once.
REQ-037 Macro undefined, busy forced 0 for 50 cycles -> valid stays high, err stays 0, then busy=1 completes normally.
